// File: rtl/reorder_buffer_pkg.sv
// Shared definitions for the reorder buffer and the rename stage.
// Holds the register-name widths, the ROB geometry and the ROB entry layout.
package reorder_buffer_pkg;

   localparam int unsigned PHYS_W    = 6;
   localparam int unsigned ARCH_W    = 5;
   localparam int unsigned ROB_DEPTH = 16;
   localparam int unsigned TAG_W     = $clog2(ROB_DEPTH);

   typedef struct packed {
      logic              valid;
      logic              done;
      logic [ARCH_W-1:0] arch_rd;
      logic [PHYS_W-1:0] phys_rd;
      logic [PHYS_W-1:0] old_phys_rd;
   } rob_entry_t;

endpackage

// File: rtl/reorder_buffer_if.sv
// Reorder buffer bus: allocation, completion and retire channels plus status.
//   master : rename/execute side (drives alloc_* and complete_*, observes the rest)
//   slave  : the reorder buffer itself
interface reorder_buffer_if;
   import reorder_buffer_pkg::*;

   // Allocation channel
   logic              alloc_valid;
   logic [ARCH_W-1:0] alloc_arch_rd;
   logic [PHYS_W-1:0] alloc_phys_rd;
   logic [PHYS_W-1:0] alloc_old_phys_rd;
   logic              alloc_ready;
   logic [TAG_W-1:0]  alloc_tag;
   // Completion channel
   logic              complete_valid;
   logic [PHYS_W-1:0] complete_phys_reg;
   // Retire channel
   logic              retire_valid;
   logic [PHYS_W-1:0] retire_phys_reg;
   logic [ARCH_W-1:0] retire_arch_reg;
   logic [PHYS_W-1:0] retire_new_phys;
   // Status
   logic [TAG_W:0]    rob_count;
   logic              complete_miss;
   logic              overflow_err;

   modport master (
      output alloc_valid, alloc_arch_rd, alloc_phys_rd, alloc_old_phys_rd,
      output complete_valid, complete_phys_reg,
      input  alloc_ready, alloc_tag,
      input  retire_valid, retire_phys_reg, retire_arch_reg, retire_new_phys,
      input  rob_count, complete_miss, overflow_err
   );

   modport slave (
      input  alloc_valid, alloc_arch_rd, alloc_phys_rd, alloc_old_phys_rd,
      input  complete_valid, complete_phys_reg,
      output alloc_ready, alloc_tag,
      output retire_valid, retire_phys_reg, retire_arch_reg, retire_new_phys,
      output rob_count, complete_miss, overflow_err
   );

endinterface

// File: rtl/reorder_buffer.sv
// In-order retire reorder buffer: circular entry array with head/tail/count.
// Ports:
//   clk   : sole clock, rising edge
//   reset : asynchronous, active-high
//   rob   : reorder_buffer_if.slave (alloc, complete, retire, status)
// Entries are allocated at tail, marked done by physical-register match on
// completion, and retired one per cycle from head once done.
module reorder_buffer
   import reorder_buffer_pkg::PHYS_W, reorder_buffer_pkg::ARCH_W, reorder_buffer_pkg::rob_entry_t;
#(
   parameter int unsigned ROB_DEPTH = reorder_buffer_pkg::ROB_DEPTH,
   parameter int unsigned TAG_W     = reorder_buffer_pkg::TAG_W
) (
   input logic               clk,
   input logic               reset,
   reorder_buffer_if.slave   rob
);

   localparam logic [TAG_W:0] FullCount = ROB_DEPTH[TAG_W:0];

   rob_entry_t        rob_q [ROB_DEPTH];
   rob_entry_t        rob_d [ROB_DEPTH];
   logic [TAG_W-1:0]  head_q, head_d;
   logic [TAG_W-1:0]  tail_q, tail_d;
   logic [TAG_W:0]    count_q, count_d;
   logic              overflow_q, overflow_d;
   logic              complete_miss_q, complete_miss_d;
   logic              retire_valid_q;
   logic [PHYS_W-1:0] retire_phys_q;
   logic [ARCH_W-1:0] retire_arch_q;
   logic [PHYS_W-1:0] retire_new_phys_q;

   logic alloc_ready;
   logic alloc_fire;
   logic retire_fire;
   logic any_match;

   // Readiness depends on registered count only, so a full ROB refuses
   // allocation even in a cycle where it retires.
   assign alloc_ready = (count_q < FullCount);
   assign alloc_fire  = rob.alloc_valid & alloc_ready;
   assign retire_fire = rob_q[head_q].valid & rob_q[head_q].done;

   always_comb begin
      rob_d           = rob_q;
      head_d          = head_q;
      tail_d          = tail_q;
      count_d         = count_q;
      overflow_d      = overflow_q | (rob.alloc_valid & ~alloc_ready);
      any_match       = 1'b0;

      // Only pre-edge valid entries can match, so the slot being allocated
      // this cycle is never marked done by a same-cycle completion.
      if (rob.complete_valid) begin
         for (int unsigned i = 0; i < ROB_DEPTH; i++) begin
            if (rob_q[i].valid && !rob_q[i].done &&
                (rob_q[i].phys_rd == rob.complete_phys_reg)) begin
               rob_d[i].done = 1'b1;
               any_match     = 1'b1;
            end
         end
      end
      complete_miss_d = rob.complete_valid & ~any_match;

      if (retire_fire) begin
         rob_d[head_q].valid = 1'b0;
         rob_d[head_q].done  = 1'b0;
         head_d              = head_q + 1'b1;
      end

      // Head and tail coincide only when empty or full; neither case lets
      // retire and alloc touch the same slot.
      if (alloc_fire) begin
         rob_d[tail_q].valid       = 1'b1;
         rob_d[tail_q].done        = 1'b0;
         rob_d[tail_q].arch_rd     = rob.alloc_arch_rd;
         rob_d[tail_q].phys_rd     = rob.alloc_phys_rd;
         rob_d[tail_q].old_phys_rd = rob.alloc_old_phys_rd;
         tail_d                    = tail_q + 1'b1;
      end

      if (alloc_fire && !retire_fire) begin
         count_d = count_q + 1'b1;
      end else if (!alloc_fire && retire_fire) begin
         count_d = count_q - 1'b1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int unsigned i = 0; i < ROB_DEPTH; i++) begin
            rob_q[i] <= '0;
         end
         head_q            <= '0;
         tail_q            <= '0;
         count_q           <= '0;
         overflow_q        <= 1'b0;
         complete_miss_q   <= 1'b0;
         retire_valid_q    <= 1'b0;
         retire_phys_q     <= '0;
         retire_arch_q     <= '0;
         retire_new_phys_q <= '0;
      end else begin
         rob_q           <= rob_d;
         head_q          <= head_d;
         tail_q          <= tail_d;
         count_q         <= count_d;
         overflow_q      <= overflow_d;
         complete_miss_q <= complete_miss_d;
         retire_valid_q  <= retire_fire;
         // Retire fields hold their last value between pulses.
         if (retire_fire) begin
            retire_phys_q     <= rob_q[head_q].old_phys_rd;
            retire_arch_q     <= rob_q[head_q].arch_rd;
            retire_new_phys_q <= rob_q[head_q].phys_rd;
         end
      end
   end

   assign rob.alloc_ready     = alloc_ready;
   assign rob.alloc_tag       = tail_q;
   assign rob.retire_valid    = retire_valid_q;
   assign rob.retire_phys_reg = retire_phys_q;
   assign rob.retire_arch_reg = retire_arch_q;
   assign rob.retire_new_phys = retire_new_phys_q;
   assign rob.rob_count       = count_q;
   assign rob.complete_miss   = complete_miss_q;
   assign rob.overflow_err    = overflow_q;

endmodule

// File: tb/tb_reorder_buffer.sv
// Directed bench for reorder_buffer: a scoreboard queue of expected entries is
// pushed on each accepted allocation and popped/compared on each retire.
module tb_reorder_buffer;
   import reorder_buffer_pkg::*;

   typedef struct {
      logic [4:0] arch;
      logic [5:0] phys;
      logic [5:0] old;
      bit         done;
   } ent_t;

   logic clk = 1'b0;
   logic reset;

   reorder_buffer_if rob_bus ();

   reorder_buffer dut (
      .clk   (clk),
      .reset (reset),
      .rob   (rob_bus)
   );

   always #5 clk = ~clk;

   int passed = 0;
   int total  = 0;
   int failed = 0;

   ent_t       mq [$];
   logic [3:0] m_tail;
   bit         m_ovf;
   logic [5:0] m_last_old;
   logic [4:0] m_last_arch;
   logic [5:0] m_last_new;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else begin
         failed++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Advance one clock with the currently driven inputs, updating the model
   // from the pre-edge state, then compare every output after the edge.
   task automatic tick();
      bit   exp_ret;
      bit   match;
      bit   acc;
      ent_t r;
      ent_t n;
      exp_ret = (mq.size() > 0) && mq[0].done;
      if (exp_ret) r = mq[0];
      match = 1'b0;
      if (rob_bus.complete_valid) begin
         foreach (mq[i]) begin
            if (!mq[i].done && mq[i].phys == rob_bus.complete_phys_reg) begin
               mq[i].done = 1'b1;
               match      = 1'b1;
            end
         end
      end
      acc = rob_bus.alloc_valid && (mq.size() < 16);
      if (rob_bus.alloc_valid && !acc) m_ovf = 1'b1;
      if (exp_ret) begin
         void'(mq.pop_front());
         m_last_old  = r.old;
         m_last_arch = r.arch;
         m_last_new  = r.phys;
      end
      if (acc) begin
         n.arch = rob_bus.alloc_arch_rd;
         n.phys = rob_bus.alloc_phys_rd;
         n.old  = rob_bus.alloc_old_phys_rd;
         n.done = 1'b0;
         mq.push_back(n);
         m_tail = m_tail + 1'b1;
      end
      @(posedge clk);
      #1;
      chk("retire_valid", 32'(rob_bus.retire_valid), 32'(exp_ret));
      chk("retire_phys_reg", 32'(rob_bus.retire_phys_reg), 32'(m_last_old));
      chk("retire_arch_reg", 32'(rob_bus.retire_arch_reg), 32'(m_last_arch));
      chk("retire_new_phys", 32'(rob_bus.retire_new_phys), 32'(m_last_new));
      chk("rob_count", 32'(rob_bus.rob_count), mq.size());
      chk("alloc_ready", 32'(rob_bus.alloc_ready), 32'(mq.size() < 16));
      chk("alloc_tag", 32'(rob_bus.alloc_tag), 32'(m_tail));
      chk("complete_miss", 32'(rob_bus.complete_miss), 32'(rob_bus.complete_valid && !match));
      chk("overflow_err", 32'(rob_bus.overflow_err), 32'(m_ovf));
      rob_bus.alloc_valid    = 1'b0;
      rob_bus.complete_valid = 1'b0;
   endtask

   task automatic step(input bit av, input logic [4:0] a, input logic [5:0] p,
                       input logic [5:0] o, input bit cv, input logic [5:0] c);
      rob_bus.alloc_valid       = av;
      rob_bus.alloc_arch_rd     = a;
      rob_bus.alloc_phys_rd     = p;
      rob_bus.alloc_old_phys_rd = o;
      rob_bus.complete_valid    = cv;
      rob_bus.complete_phys_reg = c;
      tick();
   endtask

   task automatic model_reset();
      mq.delete();
      m_tail      = '0;
      m_ovf       = 1'b0;
      m_last_old  = '0;
      m_last_arch = '0;
      m_last_new  = '0;
   endtask

   task automatic check_reset_state(input string tag);
      chk({tag, "_count"}, 32'(rob_bus.rob_count), 0);
      chk({tag, "_tag"}, 32'(rob_bus.alloc_tag), 0);
      chk({tag, "_ready"}, 32'(rob_bus.alloc_ready), 1);
      chk({tag, "_retire_valid"}, 32'(rob_bus.retire_valid), 0);
      chk({tag, "_retire_phys"}, 32'(rob_bus.retire_phys_reg), 0);
      chk({tag, "_retire_arch"}, 32'(rob_bus.retire_arch_reg), 0);
      chk({tag, "_retire_new"}, 32'(rob_bus.retire_new_phys), 0);
      chk({tag, "_miss"}, 32'(rob_bus.complete_miss), 0);
      chk({tag, "_overflow"}, 32'(rob_bus.overflow_err), 0);
   endtask

   initial begin
      reset                     = 1'b1;
      rob_bus.alloc_valid       = 1'b0;
      rob_bus.alloc_arch_rd     = '0;
      rob_bus.alloc_phys_rd     = '0;
      rob_bus.alloc_old_phys_rd = '0;
      rob_bus.complete_valid    = 1'b0;
      rob_bus.complete_phys_reg = '0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      check_reset_state("por");
      reset = 1'b0;

      // Single alloc/complete/retire.
      step(1, 5'd5, 6'd32, 6'd5, 0, 6'd0);
      step(0, 5'd0, 6'd0, 6'd0, 1, 6'd32);
      step(0, 5'd0, 6'd0, 6'd0, 0, 6'd0);
      step(0, 5'd0, 6'd0, 6'd0, 0, 6'd0);

      // Out-of-order completion, in-order retire.
      step(1, 5'd1, 6'd33, 6'd1, 0, 6'd0);
      step(1, 5'd2, 6'd34, 6'd2, 0, 6'd0);
      step(1, 5'd3, 6'd35, 6'd3, 0, 6'd0);
      step(0, 5'd0, 6'd0, 6'd0, 1, 6'd35);
      step(0, 5'd0, 6'd0, 6'd0, 1, 6'd34);
      step(0, 5'd0, 6'd0, 6'd0, 1, 6'd33);
      repeat (4) step(0, 5'd0, 6'd0, 6'd0, 0, 6'd0);

      // Completion with no matching entry.
      step(0, 5'd0, 6'd0, 6'd0, 1, 6'd50);
      step(0, 5'd0, 6'd0, 6'd0, 0, 6'd0);

      // Fill, overflow, and alloc refused while full even with a retire.
      for (int i = 0; i < 16; i++) step(1, 5'(i), 6'(10 + i), 6'(i), 0, 6'd0);
      chk("full_count", 32'(rob_bus.rob_count), 16);
      chk("full_ready", 32'(rob_bus.alloc_ready), 0);
      step(1, 5'd20, 6'd60, 6'd60, 0, 6'd0);
      step(0, 5'd0, 6'd0, 6'd0, 1, 6'd10);
      step(1, 5'd21, 6'd61, 6'd61, 0, 6'd0);
      chk("full_retire_count", 32'(rob_bus.rob_count), 15);
      for (int i = 1; i < 16; i++) step(0, 5'd0, 6'd0, 6'd0, 1, 6'(10 + i));
      repeat (3) step(0, 5'd0, 6'd0, 6'd0, 0, 6'd0);

      // Streaming traffic with pointer wrap.
      for (int k = 0; k < 40; k++) begin
         step(1, 5'(k % 32), 6'(k % 48), 6'((k + 7) % 48), k >= 2, 6'((k + 46) % 48));
      end
      step(0, 5'd0, 6'd0, 6'd0, 1, 6'd38);
      step(0, 5'd0, 6'd0, 6'd0, 1, 6'd39);
      repeat (3) step(0, 5'd0, 6'd0, 6'd0, 0, 6'd0);

      // Reset with six pending entries, three of them done behind the head.
      for (int i = 0; i < 6; i++) step(1, 5'(i + 8), 6'(40 + i), 6'(i + 1), 0, 6'd0);
      step(0, 5'd0, 6'd0, 6'd0, 1, 6'd41);
      step(0, 5'd0, 6'd0, 6'd0, 1, 6'd42);
      step(0, 5'd0, 6'd0, 6'd0, 1, 6'd43);
      reset = 1'b1;
      #1;
      model_reset();
      check_reset_state("midrst");
      @(posedge clk);
      #1;
      check_reset_state("midrst_edge");
      reset = 1'b0;
      repeat (3) step(0, 5'd0, 6'd0, 6'd0, 0, 6'd0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
